// File: rtl/life_pkg.sv
// Shared constants for the Game-of-Life display: board geometry, palette,
// cell icon ROM and cursor autorepeat period.
package life_pkg;

    localparam int LOG_W         = 6;
    localparam int LOG_H         = 5;
    localparam int CELL_SHIFT    = 3;
    localparam int REPEAT_FRAMES = 8;

    // Bit positions inside the {up,down,left,right} button bus
    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 0;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb_t;

    localparam rgb_t COL_OFF    = '{r: 2'b00, g: 2'b00, b: 2'b00};
    localparam rgb_t COL_BG     = '{r: 2'b01, g: 2'b01, b: 2'b01};
    localparam rgb_t COL_LIVE   = '{r: 2'b11, g: 2'b11, b: 2'b01};
    localparam rgb_t COL_CURSOR = '{r: 2'b11, g: 2'b00, b: 2'b00};
    localparam rgb_t COL_GRID   = '{r: 2'b01, g: 2'b01, b: 2'b10};

    // 8x8 rounded-square icon drawn inside a live cell
    function automatic logic icon_bit(input logic [2:0] px, input logic [2:0] py);
        logic [7:0] row_bits;
        case (py)
            3'd0, 3'd7: row_bits = 8'h00;
            3'd1, 3'd6: row_bits = 8'h3C;
            default:    row_bits = 8'h7E;
        endcase
        return row_bits[px];
    endfunction

endpackage

// File: rtl/life_btn_repeat.sv
// One cursor button: 2-flop synchroniser plus frame-based autorepeat.
// move fires on the first vsync tick after a press, then every REPEAT_FRAMES ticks.
module life_btn_repeat (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic frame_tick,
    output logic held,
    output logic move
);
    import life_pkg::*;

    localparam int CNT_W = $clog2(REPEAT_FRAMES);

    logic [1:0]       sync;
    logic [CNT_W-1:0] frames;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            frames <= '0;
        end else begin
            sync <= {sync[0], btn};
            // Counter parked at zero while released, so a fresh press moves on the next tick
            if (!sync[1])
                frames <= '0;
            else if (frame_tick)
                frames <= frames + 1'b1;
        end
    end

    assign held = sync[1];
    assign move = frame_tick && held && (frames == '0);

endmodule

// File: rtl/life_scanout.sv
// Game-of-Life display stage: beam -> board cell lookup, icon/cursor render,
// edit cursor and toggle requests. Define LIFE_SCANOUT_GRID_EN for faint grid lines.
module life_scanout #(
    parameter int LOG_W    = life_pkg::LOG_W,
    parameter int LOG_H    = life_pkg::LOG_H,
    parameter int FRAME_X0 = 64,
    parameter int FRAME_Y0 = 112
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [9:0]             hpos,
    input  logic [9:0]             vpos,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic                   display_on,
    output logic [LOG_W+LOG_H-1:0] mem_addr,
    input  logic                   mem_rdata,
    input  logic [3:0]             btn,
    input  logic                   btn_toggle,
    input  logic                   edit_en,
    output logic                   toggle_pulse,
    output logic [LOG_W+LOG_H-1:0] toggle_addr,
    output logic [1:0]             r,
    output logic [1:0]             g,
    output logic [1:0]             b,
    output logic                   hsync_out,
    output logic                   vsync_out
);
    import life_pkg::*;

    localparam logic [9:0] X0 = 10'(FRAME_X0);
    localparam logic [9:0] Y0 = 10'(FRAME_Y0);
    localparam logic [9:0] XW = 10'(1 << (LOG_W + CELL_SHIFT));
    localparam logic [9:0] YW = 10'(1 << (LOG_H + CELL_SHIFT));

    // ---------------- beam -> cell ----------------
    logic [9:0]       hoff, voff;
    logic             in_win, cell_edge;
    logic [LOG_W-1:0] col;
    logic [LOG_H-1:0] row;
    logic [2:0]       px, py;
    logic [LOG_W-1:0] cur_x;
    logic [LOG_H-1:0] cur_y;

    assign hoff      = hpos - X0;
    assign voff      = vpos - Y0;
    assign in_win    = (hpos >= X0) && (hoff < XW) && (vpos >= Y0) && (voff < YW);
    assign col       = hoff[LOG_W+CELL_SHIFT-1:CELL_SHIFT];
    assign row       = voff[LOG_H+CELL_SHIFT-1:CELL_SHIFT];
    assign px        = hoff[CELL_SHIFT-1:0];
    assign py        = voff[CELL_SHIFT-1:0];
    assign cell_edge = (px == 3'd0) || (px == 3'd7) || (py == 3'd0) || (py == 3'd7);

    // ---------------- stage 1 ----------------
    logic s1_vis, s1_icon, s1_cur, s1_hs, s1_vs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= '0;
            s1_vis   <= 1'b0;
            s1_icon  <= 1'b0;
            s1_cur   <= 1'b0;
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
        end else begin
            // Outside the window the RAM address is left alone; the pixel is blanked anyway
            if (in_win)
                mem_addr <= {row, col};
            s1_vis  <= display_on && in_win;
            s1_icon <= icon_bit(px, py);
            s1_cur  <= edit_en && (col == cur_x) && (row == cur_y) && cell_edge;
            s1_hs   <= hsync_in;
            s1_vs   <= vsync_in;
        end
    end

`ifdef LIFE_SCANOUT_GRID_EN
    logic s1_grid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            s1_grid <= 1'b0;
        else
            s1_grid <= (px == 3'd7) || (py == 3'd7);
    end
`endif

    // ---------------- stage 2: colour ----------------
    rgb_t pix;

    always_comb begin
        pix = COL_BG;
        if (!s1_vis)
            pix = COL_OFF;
        else if (s1_cur)
            pix = COL_CURSOR;
        else if (mem_rdata && s1_icon)
            pix = COL_LIVE;
`ifdef LIFE_SCANOUT_GRID_EN
        else if (s1_grid)
            pix = COL_GRID;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r         <= 2'b00;
            g         <= 2'b00;
            b         <= 2'b00;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            r         <= pix.r;
            g         <= pix.g;
            b         <= pix.b;
            hsync_out <= s1_hs;
            vsync_out <= s1_vs;
        end
    end

    // ---------------- edit cursor ----------------
    logic       vsync_q, frame_tick;
    logic [3:0] held, move;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vsync_q <= 1'b1;
        else
            vsync_q <= vsync_in;
    end

    assign frame_tick = vsync_in && !vsync_q;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        life_btn_repeat u_rep (
            .clk        (clk),
            .rst_n      (rst_n),
            .btn        (btn[i]),
            .frame_tick (frame_tick),
            .held       (held[i]),
            .move       (move[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x <= LOG_W'(1 << (LOG_W - 1));
            cur_y <= LOG_H'(1 << (LOG_H - 1));
        end else begin
            // Opposing buttons held together cancel; width-limited add/sub gives the wrap
            if (move[BTN_RIGHT] && !held[BTN_LEFT])
                cur_x <= cur_x + 1'b1;
            else if (move[BTN_LEFT] && !held[BTN_RIGHT])
                cur_x <= cur_x - 1'b1;
            if (move[BTN_UP] && !held[BTN_DOWN])
                cur_y <= cur_y - 1'b1;
            else if (move[BTN_DOWN] && !held[BTN_UP])
                cur_y <= cur_y + 1'b1;
        end
    end

    // ---------------- toggle request ----------------
    logic [2:0] tog_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tog_sync     <= '0;
            toggle_pulse <= 1'b0;
            toggle_addr  <= {LOG_H'(1 << (LOG_H - 1)), LOG_W'(1 << (LOG_W - 1))};
        end else begin
            tog_sync     <= {tog_sync[1:0], btn_toggle};
            toggle_pulse <= tog_sync[1] && !tog_sync[2] && edit_en;
            // Captures the cursor before any same-cycle move lands
            toggle_addr  <= {cur_y, cur_x};
        end
    end

endmodule
